// File: rtl/load_store_unit.sv
// load_store_unit: issues one LD/ST at a time to the data memory and returns loaded words with a writeback pulse.
// Optional LSU_RANGE_CHECK_EN rejects accesses whose address is at or beyond DATA_MEM_DEPTH with a fault pulse.
module load_store_unit #(
   parameter int DATA_WIDTH     = 24,
   parameter int DATA_MEM_DEPTH = 16384
) (
   input  logic                  lsu_clk,
   input  logic                  lsu_rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_instr,
   input  logic [DATA_WIDTH-1:0] req_store_data,
   output logic [DATA_WIDTH-1:0] mem_instr,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  mem_we_load,
   output logic                  mem_we_store,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  wb_valid,
   output logic [3:0]            wb_reg,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  fault,
   output logic [15:0]           access_count
);

   localparam logic [3:0] OP_LD = 4'b1010;
   localparam logic [3:0] OP_ST = 4'b1011;

   typedef enum logic [1:0] {
      IDLE,
      LD_ISSUE,
      LD_CAPT,
      ST_ISSUE
   } lsu_state_t;

   lsu_state_t r_state;
   lsu_state_t w_nextState;

   logic [DATA_WIDTH-1:0] r_memInstr;
   logic [DATA_WIDTH-1:0] r_memDataOut;
   logic [DATA_WIDTH-1:0] r_wbData;
   logic [3:0]            r_wbReg;
   logic                  r_weLoad;
   logic                  r_weStore;
   logic                  r_wbValid;
   logic                  r_fault;
   logic [15:0]           r_accessCount;

   logic w_accept;
   logic w_isLd;
   logic w_isSt;
   logic w_outOfRange;
   logic w_startLoad;
   logic w_startStore;
   logic w_faultNow;
   logic w_capture;
   logic w_countInc;

   assign req_ready = (r_state == IDLE) && !lsu_rst;
   assign w_accept  = req_valid && req_ready;
   assign w_isLd    = (req_instr[23:20] == OP_LD);
   assign w_isSt    = (req_instr[23:20] == OP_ST);

`ifdef LSU_RANGE_CHECK_EN
   logic [15:0] w_reqAddr;
   assign w_reqAddr    = req_instr[19:4];
   assign w_outOfRange = (32'(w_reqAddr) >= 32'(DATA_MEM_DEPTH));
`else
   assign w_outOfRange = 1'b0;
`endif

   // Sequencing: non-memory opcodes and rejected addresses are consumed without leaving IDLE
   always_comb begin
      w_nextState  = r_state;
      w_startLoad  = 1'b0;
      w_startStore = 1'b0;
      w_faultNow   = 1'b0;
      w_capture    = 1'b0;
      w_countInc   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept && (w_isLd || w_isSt)) begin
               if (w_outOfRange) begin
                  w_faultNow = 1'b1;
               end else if (w_isLd) begin
                  w_startLoad = 1'b1;
                  w_nextState = LD_ISSUE;
               end else begin
                  w_startStore = 1'b1;
                  w_nextState  = ST_ISSUE;
               end
            end
         end
         LD_ISSUE: begin
            w_nextState = LD_CAPT;
         end
         LD_CAPT: begin
            w_capture   = 1'b1;
            w_countInc  = 1'b1;
            w_nextState = IDLE;
         end
         ST_ISSUE: begin
            w_countInc  = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge lsu_clk or posedge lsu_rst) begin
      if (lsu_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Strobes are registered from the acceptance decision so they line up with the issue states
   always_ff @(posedge lsu_clk or posedge lsu_rst) begin
      if (lsu_rst) begin
         r_memInstr    <= '0;
         r_memDataOut  <= '0;
         r_wbData      <= '0;
         r_wbReg       <= '0;
         r_weLoad      <= 1'b0;
         r_weStore     <= 1'b0;
         r_wbValid     <= 1'b0;
         r_fault       <= 1'b0;
         r_accessCount <= '0;
      end else begin
         r_weLoad  <= w_startLoad;
         r_weStore <= w_startStore;
         r_wbValid <= w_capture;
         r_fault   <= w_faultNow;
         if (w_accept) begin
            r_memInstr <= req_instr;
            if (w_isSt) begin
               r_memDataOut <= req_store_data;
            end
         end
         if (w_capture) begin
            r_wbData <= mem_rdata;
            r_wbReg  <= r_memInstr[3:0];
         end
         if (w_countInc) begin
            r_accessCount <= r_accessCount + 16'd1;
         end
      end
   end

   assign mem_instr    = r_memInstr;
   assign mem_data_out = r_memDataOut;
   assign mem_we_load  = r_weLoad;
   assign mem_we_store = r_weStore;
   assign wb_valid     = r_wbValid;
   assign wb_reg       = r_wbReg;
   assign wb_data      = r_wbData;
   assign fault        = r_fault;
   assign access_count = r_accessCount;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, randomized transactions against a transaction-level model, and
// hand-written sequences for mid-operation reset and back-to-back acceptance.
module tb_load_store_unit;

   localparam int KIND_OTHER = 0;
   localparam int KIND_LOAD  = 1;
   localparam int KIND_STORE = 2;
   localparam int KIND_FAULT = 3;

   logic        lsu_clk = 1'b0;
   logic        lsu_rst;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_instr;
   logic [23:0] req_store_data;
   logic [23:0] mem_instr;
   logic [23:0] mem_data_out;
   logic        mem_we_load;
   logic        mem_we_store;
   logic [23:0] mem_rdata;
   logic        wb_valid;
   logic [3:0]  wb_reg;
   logic [23:0] wb_data;
   logic        fault;
   logic [15:0] access_count;

   load_store_unit #(
      .DATA_WIDTH     (24),
      .DATA_MEM_DEPTH (16384)
   ) dut (
      .lsu_clk        (lsu_clk),
      .lsu_rst        (lsu_rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_instr      (req_instr),
      .req_store_data (req_store_data),
      .mem_instr      (mem_instr),
      .mem_data_out   (mem_data_out),
      .mem_we_load    (mem_we_load),
      .mem_we_store   (mem_we_store),
      .mem_rdata      (mem_rdata),
      .wb_valid       (wb_valid),
      .wb_reg         (wb_reg),
      .wb_data        (wb_data),
      .fault          (fault),
      .access_count   (access_count)
   );

   always #5 lsu_clk = ~lsu_clk;

   // Data memory the unit talks to: registered read on the load strobe, write on the store strobe
   logic [23:0] memArr [65536];
   always @(posedge lsu_clk) begin
      if (mem_we_load) mem_rdata <= memArr[mem_instr[19:4]];
      if (mem_we_store) memArr[mem_instr[19:4]] <= mem_data_out;
   end

   // Reference model state: what memory should hold and how many accesses should have completed
   logic [23:0] refMem [65536];
   logic [15:0] modelCount;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic weLoad;
      logic weStore;
      logic wbValid;
      logic flt;
      logic ready;
   } pulse_t;

   pulse_t      trace [4];
   logic [15:0] trCount [4];
   logic [23:0] trInstr;
   logic [23:0] trData;
   logic [23:0] trWbData;
   logic [3:0]  trWbReg;

   typedef struct {
      logic [23:0] instr;
      logic [23:0] sdata;
      int          kind;
      logic [23:0] expWb;
      logic [15:0] expCount;
   } vec_t;

   vec_t vecs [7];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " instr/data"}, {16'h0, mem_instr, mem_data_out}, 64'h0);
      checkOutput({tag, " wb/count"}, {20'h0, wb_data, wb_reg, access_count}, 64'h0);
      checkOutput({tag, " pulses/ready"},
                  {59'h0, mem_we_load, mem_we_store, wb_valid, fault, req_ready}, 64'h0);
   endtask

   // Offers one instruction from IDLE and records four cycles of outputs after the acceptance edge
   task automatic applyStimulus(input logic [23:0] instr, input logic [23:0] sdata);
      @(negedge lsu_clk);
      checkOutput("ready before offer", {63'h0, req_ready}, 64'h1);
      req_valid      = 1'b1;
      req_instr      = instr;
      req_store_data = sdata;
      for (int k = 0; k < 4; k++) begin
         @(posedge lsu_clk);
         #1;
         if (k == 0) begin
            req_valid = 1'b0;
            trInstr   = mem_instr;
            trData    = mem_data_out;
         end
         if (k == 2) begin
            trWbData = wb_data;
            trWbReg  = wb_reg;
         end
         trace[k]   = {mem_we_load, mem_we_store, wb_valid, fault, req_ready};
         trCount[k] = access_count;
      end
   endtask

   // Expected cycle pattern follows the documented latencies for each kind of request
   task automatic checkTransaction(input string name, input int kind, input logic [23:0] instr,
                                   input logic [23:0] sdata, input logic [23:0] expWb,
                                   input logic [15:0] expCount);
      pulse_t exp;
      for (int k = 0; k < 4; k++) begin
         exp.weLoad  = (kind == KIND_LOAD) && (k == 0);
         exp.weStore = (kind == KIND_STORE) && (k == 0);
         exp.wbValid = (kind == KIND_LOAD) && (k == 2);
         exp.flt     = (kind == KIND_FAULT) && (k == 0);
         exp.ready   = (kind == KIND_LOAD) ? (k >= 2) : (kind == KIND_STORE) ? (k >= 1) : 1'b1;
         checkOutput($sformatf("%s pulses c%0d", name, k), 64'(trace[k]), 64'(exp));
      end
      checkOutput({name, " mem_instr"}, 64'(trInstr), 64'(instr));
      if (kind == KIND_STORE) checkOutput({name, " mem_data_out"}, 64'(trData), 64'(sdata));
      if (kind == KIND_LOAD) begin
         checkOutput({name, " wb_data"}, 64'(trWbData), 64'(expWb));
         checkOutput({name, " wb_reg"}, 64'(trWbReg), 64'(instr[3:0]));
      end
      checkOutput({name, " access_count"}, 64'(trCount[3]), 64'(expCount));
   endtask

   task automatic modelPredict(input logic [23:0] instr, input logic [23:0] sdata,
                               output int kind, output logic [23:0] expWb);
      int addr;
      addr  = int'(instr[19:4]);
      expWb = 24'h0;
      kind  = KIND_OTHER;
      if (instr[23:20] == 4'hA || instr[23:20] == 4'hB) begin
`ifdef LSU_RANGE_CHECK_EN
         if (addr >= 16384) kind = KIND_FAULT;
         else kind = (instr[23:20] == 4'hA) ? KIND_LOAD : KIND_STORE;
`else
         kind = (instr[23:20] == 4'hA) ? KIND_LOAD : KIND_STORE;
`endif
      end
      if (kind == KIND_LOAD) begin
         expWb      = refMem[addr];
         modelCount = modelCount + 16'd1;
      end else if (kind == KIND_STORE) begin
         refMem[addr] = sdata;
         modelCount   = modelCount + 16'd1;
      end
   endtask

   task automatic runModelled(input string name, input logic [23:0] instr, input logic [23:0] sdata);
      int          kind;
      logic [23:0] expWb;
      modelPredict(instr, sdata, kind, expWb);
      applyStimulus(instr, sdata);
      checkTransaction(name, kind, instr, sdata, expWb, modelCount);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int          kind;
      logic [23:0] expWb;
      logic [23:0] instr;
      logic [23:0] sdata;
      logic [3:0]  op;
      logic [15:0] addr;
      logic [23:0] bbInstr [3];
      logic [23:0] bbData [3];
      int          accCyc [3];
      int          idx;
      logic        readyBefore;
      logic        wbSeen;

      lsu_rst        = 1'b1;
      req_valid      = 1'b0;
      req_instr      = 24'h0;
      req_store_data = 24'h0;
      modelCount     = 16'h0;
      for (int a = 0; a < 65536; a++) begin
         memArr[a] = 24'(a * 3);
         refMem[a] = 24'(a * 3);
      end

      vecs[0] = '{24'hB000A3, 24'h00000A, KIND_STORE, 24'h0, 16'd1};
      vecs[1] = '{24'hA000A4, 24'h0, KIND_LOAD, 24'h00000A, 16'd2};
      vecs[2] = '{24'hA00011, 24'h0, KIND_LOAD, 24'h000003, 16'd3};
      vecs[3] = '{24'h030102, 24'h777777, KIND_OTHER, 24'h0, 16'd3};
      vecs[4] = '{24'hB0FFF7, 24'h123456, KIND_STORE, 24'h0, 16'd4};
      vecs[5] = '{24'hA0FFF2, 24'h0, KIND_LOAD, 24'h123456, 16'd5};
`ifdef LSU_RANGE_CHECK_EN
      vecs[6] = '{24'hA40001, 24'h0, KIND_FAULT, 24'h0, 16'd5};
`else
      vecs[6] = '{24'hA40001, 24'h0, KIND_LOAD, 24'h00C000, 16'd6};
`endif

      #3;
      checkAllZero("power-on reset");
      @(negedge lsu_clk);
      @(negedge lsu_clk);
      lsu_rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         modelPredict(vecs[i].instr, vecs[i].sdata, kind, expWb);
         applyStimulus(vecs[i].instr, vecs[i].sdata);
         checkTransaction($sformatf("vec%0d", i), vecs[i].kind, vecs[i].instr, vecs[i].sdata,
                          vecs[i].expWb, vecs[i].expCount);
      end

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: op = 4'hA;
            4, 5, 6, 7: op = 4'hB;
            8:          op = 4'($urandom_range(0, 9));
            default:    op = ($urandom_range(0, 1) == 0) ? 4'hA : 4'hB;
         endcase
         addr  = 16'($urandom_range(0, 15));
         if (i % 10 == 9) addr = 16'($urandom_range(16384, 65535));
         instr = {op, addr, 4'($urandom_range(0, 15))};
         sdata = 24'($urandom);
         runModelled($sformatf("rand%0d", i), instr, sdata);
      end

      // Reset while the load is waiting to capture: nothing may be written back
      @(negedge lsu_clk);
      req_valid = 1'b1;
      req_instr = 24'hA00015;
      @(posedge lsu_clk);
      #1;
      req_valid = 1'b0;
      @(posedge lsu_clk);
      #1;
      lsu_rst = 1'b1;
      #1;
      checkAllZero("mid-load reset");
      @(negedge lsu_clk);
      lsu_rst    = 1'b0;
      modelCount = 16'h0;
      wbSeen     = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge lsu_clk);
         #1;
         wbSeen = wbSeen | wb_valid;
      end
      checkOutput("no wb after reset", {63'h0, wbSeen}, 64'h0);
      checkOutput("count after reset", 64'(access_count), 64'h0);
      runModelled("load after reset", 24'hA00012, 24'h0);

      // Back-to-back ST, LD, ST with valid held: acceptances expected at cycles 0, 2, 5
      bbInstr = '{24'hB00027, 24'hA00023, 24'hB00038};
      bbData  = '{24'h55AA55, 24'h000000, 24'h0F0F0F};
      accCyc  = '{-1, -1, -1};
      idx     = 0;
      @(negedge lsu_clk);
      req_valid      = 1'b1;
      req_instr      = bbInstr[0];
      req_store_data = bbData[0];
      for (int cyc = 0; cyc < 12 && idx < 3; cyc++) begin
         readyBefore = req_ready;
         @(posedge lsu_clk);
         #1;
         if (readyBefore) begin
            accCyc[idx] = cyc;
            idx++;
            if (idx < 3) begin
               req_instr      = bbInstr[idx];
               req_store_data = bbData[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
         @(negedge lsu_clk);
      end
      req_valid = 1'b0;
      checkOutput("b2b accept count", 64'(idx), 64'd3);
      checkOutput("b2b accept cycles", {16'h0, 16'(accCyc[0]), 16'(accCyc[1]), 16'(accCyc[2])},
                  {16'h0, 16'd0, 16'd2, 16'd5});
      refMem[2]  = bbData[0];
      refMem[3]  = bbData[2];
      modelCount = modelCount + 16'd3;
      repeat (3) @(negedge lsu_clk);
      checkOutput("b2b access_count", 64'(access_count), 64'(modelCount));
      checkOutput("b2b wb_data", 64'(wb_data), 64'(refMem[2]));
      checkOutput("b2b wb_reg", 64'(wb_reg), 64'd3);
      runModelled("b2b readback", 24'hA00039, 24'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the data-memory port: accepts one decoded LD/ST instruction at a time from the execute stage and drives the memory's load/store strobes, address-bearing instruction word and store data. It captures the registered load data one cycle after the load strobe and returns it with a one-cycle register-writeback pulse. It sits between the execute stage and the memory block, in the opposite direction to the memory's load/store port.

## Interface
- DATA_WIDTH, 24, data word width
- DATA_MEM_DEPTH, 16384, number of valid data-memory words (used by range check)
- lsu_clk  in  1  clock, all state updates on posedge
- lsu_rst  in  1  asynchronous, active-high reset
- req_valid  in  1  instruction offered
- req_ready  out  1  unit can accept; high only in IDLE and not in reset
- req_instr  in  24  instruction; [23:20] opcode (4'b1010 LD, 4'b1011 ST), [19:4] address, [3:0] register
- req_store_data  in  24  register value to store (sampled at acceptance)
- mem_instr  out  24  latched instruction to memory's instruction_code
- mem_data_out  out  24  latched store data to memory's data_in_mem
- mem_we_load  out  1  registered load strobe
- mem_we_store  out  1  registered store strobe
- mem_rdata  in  24  memory's registered load data
- wb_valid  out  1  one-cycle writeback pulse
- wb_reg  out  4  destination register
- wb_data  out  24  loaded word
- fault  out  1  one-cycle out-of-range pulse
- access_count  out  16  completed LD+ST accesses, wraps

## Operation
- States: IDLE, LD_ISSUE, LD_CAPT, ST_ISSUE.
- Acceptance = req_valid && req_ready at a posedge. Accepted instruction is latched into mem_instr. req_store_data is latched into mem_data_out on ST only.
- IDLE, LD accepted -> LD_ISSUE. ST accepted -> ST_ISSUE. Any other opcode is accepted and dropped: no strobe, no writeback, and the unit stays in IDLE.
- LD_ISSUE: mem_we_load=1 -> LD_CAPT.
- LD_CAPT: mem_we_load=0; wb_data<=mem_rdata, wb_reg<=mem_instr[3:0], wb_valid<=1, access_count+1 -> IDLE.
- ST_ISSUE: mem_we_store=1 for exactly this cycle; access_count+1 -> IDLE.
- Strobes, wb_valid and fault are registered pulses, never high two consecutive cycles for one request.
- wb_data/wb_reg hold their values until the next load capture. mem_instr and mem_data_out hold until the next acceptance.
- Reset (any time, including mid-operation): state IDLE; every output 0 (mem_instr, mem_data_out, wb_data, wb_reg, access_count = 0; all pulses 0; req_ready 0 while lsu_rst high). The in-flight request is dropped with no writeback.

## Timing
- Acceptance edge E0. Load: mem_we_load high E0–E1; memory registers data at E1; wb_valid high E2–E3. Acceptance-to-writeback latency is 2 cycles. req_ready returns at E2.
- Store: mem_we_store high E0–E1; memory writes at E1; req_ready returns at E1.
- Back-to-back: with req_valid held, consecutive stores are accepted every 2 cycles and loads every 3 cycles.
- access_count wraps 16'hFFFF -> 0.

## Configuration
- LSU_RANGE_CHECK_EN defined: at acceptance, an LD/ST with address[19:4] >= DATA_MEM_DEPTH produces no strobe, no writeback and no count. fault pulses the cycle after acceptance, and the unit stays in IDLE.
- Undefined: no check; the address is passed through unchanged and fault is tied to 0.

## Test plan
- Store: req_instr=24'hB000A3, req_store_data=24'h00000A, accepted at E0 -> mem_we_store=1 for one cycle with mem_instr=24'hB000A3 and mem_data_out=24'h00000A; access_count=1.
- Load: req_instr=24'hA00011; bench memory returns 24'h000003 after the strobe -> wb_valid pulse at E2 with wb_reg=1 and wb_data=24'h000003; no mem_we_store.
- Non-memory opcode 24'h030102 -> accepted, no strobes, no wb_valid, req_ready stays 1, access_count unchanged.
- Range (macro on): req_instr=24'hA40001 (address 16384) -> fault pulse, no mem_we_load, access_count unchanged. Macro off: mem_we_load pulses.
- Reset asserted during LD_CAPT -> all outputs 0 immediately, no wb_valid; after release, req_ready=1 and the next load completes normally.
- Back-to-back: ST, LD, ST held valid -> acceptances at cycles 0, 2, 5; access_count=3.
